// File: rtl/calyx_prims_pkg.sv
// Shared types for the calyx-style primitive library: responder handshake states
// and a small decode helper used by multi-cycle leaf primitives.
package calyx_prims_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resp_state_t;

    // The unused encoding 2'd3 behaves as IDLE so a corrupted state recovers on its own.
    function automatic logic is_idle(input resp_state_t state);
        return (state == IDLE) || (state == resp_state_t'(2'd3));
    endfunction

endpackage

// File: rtl/iter_mult_responder.sv
// Multi-cycle shift-add multiplier on the responder side of a valid/ready handshake.
// One multiplier bit is consumed per cycle; ready pulses for one cycle with the product on out.
module iter_mult_responder
    import calyx_prims_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             ready
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    resp_state_t      state_r;
    resp_state_t      state_next_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_sum_s;
    logic [WIDTH-1:0] out_r;
    logic [CW-1:0]    cnt_r;
    logic             accept_s;
    logic             last_s;

    assign out = out_r;

    // Next-state, step add and ready decode from registered state only.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        ready        = (state_r == DONE);
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
        case (state_r)
            BUSY: begin
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                if (is_idle(state_r) && valid) begin
                    accept_s     = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
        endcase
    end

    // State and shift-add datapath; out only updates on the step that finishes the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            out_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                mcand_r  <= left;
                mplier_r <= right;
                acc_r    <= {WIDTH{1'b0}};
                cnt_r    <= {CW{1'b0}};
            end else if (state_r == BUSY) begin
                acc_r    <= acc_sum_s;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r + CW'(1);
                if (last_s) begin
                    out_r <= acc_sum_s;
                end else begin
                    out_r <= out_r;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

endmodule

// File: tb/tb_iter_mult_responder.sv
// Directed and table-driven bench for iter_mult_responder at WIDTH=32 and WIDTH=4.
module tb_iter_mult_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] left, right, out;
    logic        ready;
    logic        valid4;
    logic [3:0]  left4, right4, out4;
    logic        ready4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    iter_mult_responder #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .valid(valid),
        .left(left), .right(right), .out(out), .ready(ready)
    );

    iter_mult_responder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .valid(valid4),
        .left(left4), .right(right4), .out(out4), .ready(ready4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Hold valid until ready, then drop it; latency counts edges from the accepting edge on.
    task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        valid = 1'b1; left = a; right = b;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready && n < 100);
        check({name, " latency"}, n, 33);
        check({name, " out"}, out, exp);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        check({name, " pulse width"}, {31'd0, ready}, 32'd0);
    endtask

    task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        valid4 = 1'b1; left4 = a; right4 = b;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready4 && n < 20);
        check({name, " latency"}, n, 5);
        check({name, " out"}, {28'd0, out4}, {28'd0, exp});
        @(negedge clk);
        valid4 = 1'b0;
        @(posedge clk); #1;
        check({name, " pulse width"}, {31'd0, ready4}, 32'd0);
    endtask

    task automatic count_ready(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check({name, " spurious ready"}, seen, 0);
    endtask

    initial begin
        int n, t1, t2;
        logic [3:0] ra, rb;

        vecs[0] = '{a: 32'd6,          b: 32'd7,          exp: 32'd42};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 32'hFFFF_FFFE};
        vecs[2] = '{a: 32'd0,          b: 32'd5,          exp: 32'd0};
        vecs[3] = '{a: 32'h0000_FFFF,  b: 32'h0001_0001,  exp: 32'hFFFF_FFFF};
        vecs[4] = '{a: 32'h8000_0000,  b: 32'd2,          exp: 32'd0};
        vecs[5] = '{a: 32'd1000,       b: 32'd1000,       exp: 32'd1000000};
        vecs[6] = '{a: 32'h1234_5678,  b: 32'd1,          exp: 32'h1234_5678};

        reset = 1'b1; valid = 1'b0; left = 32'd0; right = 32'd0;
        valid4 = 1'b0; left4 = 4'd0; right4 = 4'd0;
        repeat (2) @(negedge clk);
        check("reset out", out, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset out4", {28'd0, out4}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run32($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Reset during BUSY: out clears immediately and the abandoned product never completes.
        @(negedge clk);
        valid = 1'b1; left = 32'd6; right = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset out", out, 32'd0);
        check("midreset ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        count_ready("midreset", 40);
        run32("after reset", 32'd3, 32'd4, 32'd12);

        // Back-to-back: valid held through DONE, new operands presented immediately.
        @(negedge clk);
        valid = 1'b1; left = 32'd5; right = 32'd5;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 100);
        t1 = cyc;
        check("b2b first out", out, 32'd25);
        @(negedge clk);
        left = 32'd9; right = 32'd9;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 100);
        t2 = cyc;
        check("b2b spacing", t2 - t1, 34);
        check("b2b second out", out, 32'd81);
        @(negedge clk);
        valid = 1'b0;
        count_ready("b2b", 40);

        // Operands scrambled after acceptance and valid dropped mid-BUSY.
        @(negedge clk);
        valid = 1'b1; left = 32'd1234; right = 32'd567;
        @(posedge clk); #1;
        n = 1;
        while (!ready && n < 100) begin
            @(negedge clk);
            left = $urandom; right = $urandom;
            if (n == 6) valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("latched latency", n, 33);
        check("latched out", out, 32'd699678);
        count_ready("latched", 40);

        run4("w4 max", 4'hF, 4'hF, 4'h1);
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run4($sformatf("w4 rand%0d", i), ra, rb, 4'((int'(ra) * int'(rb)) % 16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
